wb_write_queue: RTL and testbench
=================================

Name: wb_write_queue

Overview:
- Write-side initiator for the core register file's single write port.
- Merges the in-order primary writeback stream with results from long-latency units (load miss, mul/div) that arrive over a valid/ready handshake.
- Holds those late results in a small FIFO and drains them onto the register file write port in cycles when the primary stream is idle.
- Exposes two combinational lookup ports so the hazard/forwarding logic can find values still queued and not yet written.

Parameters:
- DATA_WIDTH, 64, width of a register value (matches CorePack data_t).
- ADDR_WIDTH, 5, register index width (matches CorePack reg_ind_t).
- DEPTH, 4, number of queue slots; must be a power of two and at least 2.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- pri_we  in  1  primary writeback valid
- pri_addr  in  ADDR_WIDTH  primary destination register
- pri_data  in  DATA_WIDTH  primary write value
- enq_valid  in  1  late result valid
- enq_ready  out  1  queue can accept a late result
- enq_addr  in  ADDR_WIDTH  late result destination register
- enq_data  in  DATA_WIDTH  late result value
- rf_we  out  1  to register file we
- rf_write_addr  out  ADDR_WIDTH  to register file write_addr
- rf_write_data  out  DATA_WIDTH  to register file write_data
- lookup_addr_1 / lookup_addr_2  in  ADDR_WIDTH  query indices
- lookup_hit_1 / lookup_hit_2  out  1  a live queued entry targets the queried register
- lookup_data_1 / lookup_data_2  out  DATA_WIDTH  value of the youngest matching live entry; 0 when there is no hit
- count  out  $clog2(DEPTH+1)  occupied slots, including killed slots
- empty  out  1  count == 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: all slots invalid, head = tail = 0, count = 0, empty = 1.
  - While rst is high: enq_ready = 0, rf_we = 0, rf_write_addr = 0, rf_write_data = 0, lookup_hit_* = 0.
  - Reset mid-operation discards all queued entries; they are never written.
- Slot contents: {live, addr, data}. The FIFO advances head/tail pointers and wraps modulo DEPTH.
- Enqueue handshake:
  - enq_ready = (count < DEPTH). It depends on registered count only; a same-cycle pop does not free space.
  - A transfer occurs when enq_valid && enq_ready. It is written at tail, live = 1, tail++.
  - enq_addr == 0: the handshake completes but nothing is stored.
  - enq_valid held while full: no transfer; the producer must hold its data stable.
- Minimum latency: an enqueued result reaches rf_we no earlier than the next cycle. There is no bypass through an empty queue.
- Write-port arbitration (combinational, per cycle):
  1. If pri_we && pri_addr != 0: rf_* = primary. The head is popped only if it is killed.
  2. Else if !empty and the head is live: rf_we = 1, rf_* = head contents, pop.
  3. Else if !empty and the head is killed: rf_we = 0, pop.
  4. Else: rf_we = 0.
- Squash: a primary write (pri_we, pri_addr != 0) clears live on every stored entry with a matching addr, at that clock edge.
  - The primary result is newer and must not be overwritten later.
  - An entry enqueued in the same cycle to the same register is not squashed; it stays live and is written later.
- Killed slots still occupy count until popped.
- Simultaneous enqueue and pop: count is unchanged, both pointers advance.
- Lookup:
  - hit = some live entry has addr == lookup_addr, and lookup_addr != 0.
  - data = youngest such entry, i.e. the closest to tail.
  - Only registered contents are searched. The same-cycle enqueue and the same-cycle primary are not visible.
- Ordering guarantee: two queued writes to the same register reach the register file in enqueue order.

Test Plan:
- Reset, then enqueue {x5, 0xAA} with pri_we = 0 → next cycle rf_we = 1, rf_write_addr = 5, rf_write_data = 0xAA; count goes 1 → 0; empty = 1.
- Hold pri_we = 1 to x1..x6 continuously and enqueue 5 results to x10..x14 → the 5th sees enq_ready = 0 while count = 4. Drop pri_we → x10..x13 appear on consecutive cycles, in order.
- Queue holds {x7, 0x11} and pri_we writes x7 = 0x22 → lookup x7 hit = 0 from the next cycle. The later pop gives rf_we = 0 for that slot, so the register file keeps 0x22.
- Enqueue {x3, 0x1} then {x3, 0x2} → lookup x3 returns 0x2. Drain writes 0x1 and then 0x2.
- Enqueue with enq_addr = 0 → the handshake completes, count stays 0, no rf_we.
- Fill 3 slots, assert rst for one cycle → count = 0, rf_we = 0 on the following cycles, lookups miss.

Source files
------------

// File: rtl/wb_write_queue.sv
// wb_write_queue: merges the primary writeback stream with queued late results onto one register file write port.
module wb_write_queue #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pri_we,
    input  logic [ADDR_WIDTH-1:0]        pri_addr,
    input  logic [DATA_WIDTH-1:0]        pri_data,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [ADDR_WIDTH-1:0]        enq_addr,
    input  logic [DATA_WIDTH-1:0]        enq_data,
    output logic                         rf_we,
    output logic [ADDR_WIDTH-1:0]        rf_write_addr,
    output logic [DATA_WIDTH-1:0]        rf_write_data,
    input  logic [ADDR_WIDTH-1:0]        lookup_addr_1,
    input  logic [ADDR_WIDTH-1:0]        lookup_addr_2,
    output logic                         lookup_hit_1,
    output logic                         lookup_hit_2,
    output logic [DATA_WIDTH-1:0]        lookup_data_1,
    output logic [DATA_WIDTH-1:0]        lookup_data_2,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]      live_q, live_d;
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  pri_act, head_live, pop, push;

    assign count = count_q;
    assign empty = count_q == '0;

    always_comb begin
        pri_act   = pri_we && pri_addr != '0;
        head_live = !empty && live_q[head_q];
        // A busy primary port only lets killed heads drain.
        pop       = !empty && (!live_q[head_q] || !pri_act);
        enq_ready = !rst && count_q < CW'(DEPTH);
        push      = enq_valid && enq_ready && enq_addr != '0;
        live_d    = live_q;
        addr_d    = addr_q;
        data_d    = data_q;
        for (int i = 0; i < DEPTH; i++)
            if (pri_act && addr_q[i] == pri_addr) live_d[i] = 1'b0;
        if (pop) live_d[head_q] = 1'b0;
        if (push) begin
            live_d[tail_q] = 1'b1;
            addr_d[tail_q] = enq_addr;
            data_d[tail_q] = enq_data;
        end
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        rf_we         = !rst && (pri_act || head_live);
        rf_write_addr = rst ? '0 : pri_act ? pri_addr : head_live ? addr_q[head_q] : '0;
        rf_write_data = rst ? '0 : pri_act ? pri_data : head_live ? data_q[head_q] : '0;
    end

    // Walk oldest to youngest so the last match is the youngest.
    always_comb begin
        lookup_hit_1  = 1'b0;
        lookup_hit_2  = 1'b0;
        lookup_data_1 = '0;
        lookup_data_2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst && lookup_addr_1 != '0 && live_q[head_q + PW'(i)] &&
                addr_q[head_q + PW'(i)] == lookup_addr_1) begin
                lookup_hit_1  = 1'b1;
                lookup_data_1 = data_q[head_q + PW'(i)];
            end
            if (!rst && lookup_addr_2 != '0 && live_q[head_q + PW'(i)] &&
                addr_q[head_q + PW'(i)] == lookup_addr_2) begin
                lookup_hit_2  = 1'b1;
                lookup_data_2 = data_q[head_q + PW'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            live_q  <= live_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
        addr_q <= addr_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: queue-model scoreboard for wb_write_queue with directed and random stimulus.
module tb_wb_write_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pri_we, enq_valid, enq_ready, rf_we;
    logic [4:0]  pri_addr, enq_addr, rf_write_addr, lookup_addr_1, lookup_addr_2;
    logic [63:0] pri_data, enq_data, rf_write_data, lookup_data_1, lookup_data_2;
    logic        lookup_hit_1, lookup_hit_2, empty;
    logic [2:0]  count;

    typedef struct packed {
        logic        live;
        logic [4:0]  a;
        logic [63:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [68:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          stalled = 0;

    always #5 clk = ~clk;

    wb_write_queue #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .pri_we(pri_we), .pri_addr(pri_addr), .pri_data(pri_data),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr), .enq_data(enq_data),
        .rf_we(rf_we), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .lookup_addr_1(lookup_addr_1), .lookup_addr_2(lookup_addr_2),
        .lookup_hit_1(lookup_hit_1), .lookup_hit_2(lookup_hit_2),
        .lookup_data_1(lookup_data_1), .lookup_data_2(lookup_data_2),
        .count(count), .empty(empty)
    );

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register-file writes are popped from the scoreboard as the DUT presents them.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rf_write unexpected: got %0h/%0h, no write expected at %0t",
                         rf_write_addr, rf_write_data, $time);
            end else begin
                chk("rf_write", {rf_write_addr, rf_write_data}, exp_q.pop_front());
            end
        end
    end

    function automatic void look(input logic [4:0] la, output logic h, output logic [63:0] d);
        h = 1'b0;
        d = '0;
        foreach (mq[i])
            if (la != 0 && mq[i].live && mq[i].a == la) begin
                h = 1'b1;
                d = mq[i].d;
            end
    endfunction

    task automatic cycle();
        logic        pri, er, eh1, eh2;
        logic [63:0] ed1, ed2;
        int          ec;
        ent_t        e;
        ec = mq.size();
        if (rst) begin
            er = 0; eh1 = 0; eh2 = 0; ed1 = '0; ed2 = '0;
            mq.delete();
            stalled = 0;
        end else begin
            er = ec < DEPTH;
            look(lookup_addr_1, eh1, ed1);
            look(lookup_addr_2, eh2, ed2);
            pri = pri_we && pri_addr != 0;
            if (pri) begin
                exp_q.push_back({pri_addr, pri_data});
                if (ec > 0 && !mq[0].live) void'(mq.pop_front());
            end else if (ec > 0) begin
                e = mq.pop_front();
                if (e.live) exp_q.push_back({e.a, e.d});
            end
            if (pri)
                foreach (mq[i])
                    if (mq[i].a == pri_addr) begin
                        e = mq[i];
                        e.live = 0;
                        mq[i] = e;
                    end
            if (enq_valid && er && enq_addr != 0) mq.push_back({1'b1, enq_addr, enq_data});
            stalled = enq_valid && !er;
        end
        @(negedge clk);
        chk("enq_ready", 69'(enq_ready), 69'(er));
        chk("count", 69'(count), 69'(ec));
        chk("empty", 69'(empty), 69'(ec == 0));
        chk("hit_1", 69'(lookup_hit_1), 69'(eh1));
        chk("data_1", 69'(lookup_data_1), 69'(ed1));
        chk("hit_2", 69'(lookup_hit_2), 69'(eh2));
        chk("data_2", 69'(lookup_data_2), 69'(ed2));
        if (rst) chk("rst_rf_out", {rf_we, rf_write_addr, rf_write_data}, '0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pri_we = 0; pri_addr = 0; pri_data = 0;
        enq_valid = 0; enq_addr = 0; enq_data = 0;
        lookup_addr_1 = 0; lookup_addr_2 = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        cycle();
        rst = 0;
        // single late result drains the next cycle
        enq_valid = 1; enq_addr = 5; enq_data = 64'hAA;
        cycle();
        enq_valid = 0;
        cycle();
        cycle();
        // fill behind a busy primary stream, then drain in order
        for (int i = 0; i < 5; i++) begin
            pri_we = 1; pri_addr = 5'(i + 1); pri_data = 64'(i + 32);
            enq_valid = 1; enq_addr = 5'(10 + i); enq_data = 64'(256 + i);
            cycle();
        end
        enq_valid = 0; pri_addr = 6;
        cycle();
        pri_we = 0;
        repeat (5) cycle();
        // squash by a newer primary write
        pri_we = 1; pri_addr = 1; enq_valid = 1; enq_addr = 7; enq_data = 64'h11;
        lookup_addr_1 = 7;
        cycle();
        enq_valid = 0; pri_addr = 7; pri_data = 64'h22;
        cycle();
        pri_we = 0;
        repeat (2) cycle();
        // two writes to one register: youngest visible, drain in order
        pri_we = 1; pri_addr = 1; enq_valid = 1; enq_addr = 3; enq_data = 64'h1;
        lookup_addr_1 = 3; lookup_addr_2 = 3;
        cycle();
        enq_data = 64'h2;
        cycle();
        enq_valid = 0;
        cycle();
        pri_we = 0;
        repeat (3) cycle();
        // enqueue to x0 is accepted but dropped
        enq_valid = 1; enq_addr = 0; enq_data = 64'h55;
        cycle();
        enq_valid = 0;
        cycle();
        // reset mid-operation discards queued entries
        pri_we = 1; pri_addr = 1; lookup_addr_1 = 8; lookup_addr_2 = 9;
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1; enq_addr = 5'(8 + i); enq_data = 64'(i + 77);
            cycle();
        end
        enq_valid = 0; rst = 1;
        cycle();
        rst = 0; pri_we = 0;
        repeat (3) cycle();
        // randomized traffic with small address range for collisions
        for (int n = 0; n < 3000; n++) begin
            rst = $urandom_range(0, 299) == 0;
            pri_we = $urandom_range(0, 99) < 50;
            pri_addr = 5'($urandom_range(0, 7));
            pri_data = {$urandom, $urandom};
            if (!stalled) begin
                enq_valid = $urandom_range(0, 99) < 60;
                enq_addr = 5'($urandom_range(0, 7));
                enq_data = {$urandom, $urandom};
            end
            lookup_addr_1 = 5'($urandom_range(0, 7));
            lookup_addr_2 = 5'($urandom_range(0, 7));
            cycle();
        end
        rst = 0;
        idle();
        repeat (DEPTH + 2) cycle();
        chk("scoreboard_drained", 69'(exp_q.size()), 69'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
